// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencer sharing one iterative divider among NREQ requesters.
// Optional WAIT-state timeout is built only when DIV_ARB_TIMEOUT_EN is defined.
module div_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ*DW-1:0] i_a,
  input  logic [NREQ*DW-1:0] i_b,
  output logic [NREQ-1:0]    o_gnt,
  output logic               o_div_en,
  output logic [DW-1:0]      o_div_a,
  output logic [DW-1:0]      o_div_b,
  input  logic               i_div_fin,
  input  logic [DW-1:0]      i_div_result,
  output logic               o_rsp_vld,
  output logic [NREQ-1:0]    o_rsp_id,
  output logic [DW-1:0]      o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_busy
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     ptr, ptr_nxt, sel_idx;
  logic [PW:0]       scan;
  logic              sel_found;
  logic [NREQ-1:0]   sel_gnt, cur_id, rsp_id;
  logic [DW-1:0]     sel_a, sel_b, div_a, div_b, rsp_data;
  logic              rsp_err;
  logic              b_zero;
  logic              timed_out;

  // First requester at or after ptr, scanning upward with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    scan      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan = {1'b0, ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!sel_found && i_req[scan[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = scan[PW-1:0];
      end
    end
    sel_gnt = '0;
    if (sel_found) sel_gnt[sel_idx] = 1'b1;
    sel_a   = i_a[32'(sel_idx)*DW +: DW];
    sel_b   = i_b[32'(sel_idx)*DW +: DW];
    ptr_nxt = (sel_idx == PW'(NREQ-1)) ? '0 : sel_idx + PW'(1);
  end

  assign b_zero = (div_b == '0);

`ifdef DIV_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] wait_cnt;

  // Cleared while in ISSUE so the count starts at zero on the first WAIT cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)            wait_cnt <= '0;
    else if (state == ISSUE) wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + CW'(1);
  end

  assign timed_out = (state == WAIT) && (wait_cnt == CW'(TIMEOUT-1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = ISSUE;
      ISSUE:   state_nxt = b_zero ? RESP : WAIT;
      WAIT:    if (i_div_fin || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_gnt     = '0;
    o_div_en  = 1'b0;
    o_rsp_vld = 1'b0;
    o_busy    = 1'b1;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_rst_n) o_gnt = sel_gnt;
      end
      ISSUE:   o_div_en  = !b_zero;
      RESP:    o_rsp_vld = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr      <= '0;
      div_a    <= '0;
      div_b    <= '0;
      cur_id   <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sel_found) begin
          div_a  <= sel_a;
          div_b  <= sel_b;
          cur_id <= sel_gnt;
          ptr    <= ptr_nxt;
        end
        ISSUE: if (b_zero) begin
          rsp_id   <= cur_id;
          rsp_data <= {1'b0, {(DW-1){1'b1}}};
          rsp_err  <= 1'b1;
        end
        WAIT: if (i_div_fin) begin
          rsp_id   <= cur_id;
          rsp_data <= i_div_result;
          rsp_err  <= 1'b0;
        end else if (timed_out) begin
          rsp_id   <= cur_id;
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_div_a    = div_a;
  assign o_div_b    = div_b;
  assign o_rsp_id   = rsp_id;
  assign o_rsp_data = rsp_data;
  assign o_rsp_err  = rsp_err;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: requester/divider models plus a transaction-timing reference model.
// Builds with or without DIV_ARB_TIMEOUT_EN (TIMEOUT overridden to 8).
module tb_div_arbiter;
  localparam int NREQ    = 4;
  localparam int DW      = 16;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam int TMO     = 8;
`else
  localparam int TMO     = 64;
`endif
  localparam int LAT_RAND = -1;
  localparam int NOFIN    = -2;
  localparam int FOREVER  = 1 << 30;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] a_bus, b_bus;
  logic [NREQ-1:0]    gnt;
  logic               div_en;
  logic [DW-1:0]      div_a, div_b;
  logic               fin;
  logic [DW-1:0]      res;
  logic               rsp_vld;
  logic [NREQ-1:0]    rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               busy;

  div_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_a(a_bus), .i_b(b_bus),
    .o_gnt(gnt), .o_div_en(div_en), .o_div_a(div_a), .o_div_b(div_b),
    .i_div_fin(fin), .i_div_result(res), .o_rsp_vld(rsp_vld), .o_rsp_id(rsp_id),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Requester state
  logic [DW-1:0]   ra [NREQ];
  logic [DW-1:0]   rb [NREQ];
  logic [NREQ-1:0] raise, drop;
  int              p_new;
  bit              stray_en;
  int              fix_lat;

  // Reference model: transaction timeline derived from grant cycle and divider latency
  int              m_ptr, next_grant, en_cyc, fin_cyc, rsp_cyc, w_lo, w_hi;
  logic [DW-1:0]   m_a, m_b, e_data, p_data;
  logic [NREQ-1:0] e_id, p_id;
  logic            e_err, p_err;
  int              gl[$];
  int              gc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Stand-in quotient returned by the divider model (fixed-point a*2^8/b).
  function automatic logic [DW-1:0] model_div(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return DW'((sa * 256) / sb);
  endfunction

  task automatic model_reset();
    m_ptr = 0; next_grant = 0; en_cyc = -1; fin_cyc = -1; rsp_cyc = -1;
    w_lo = -1; w_hi = -1;
    m_a = '0; m_b = '0; e_data = '0; e_id = '0; e_err = 1'b0;
    p_data = '0; p_id = '0; p_err = 1'b0;
    raise = '0; drop = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  gnt, 0);
    check({tag, "_en"},   div_en, 0);
    check({tag, "_a"},    div_a, 0);
    check({tag, "_b"},    div_b, 0);
    check({tag, "_vld"},  rsp_vld, 0);
    check({tag, "_id"},   rsp_id, 0);
    check({tag, "_data"}, rsp_data, 0);
    check({tag, "_err"},  rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic step();
    logic [NREQ-1:0] exp_gnt;
    bit exp_busy, granted;
    int gi, k, lat;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < NREQ; i++) begin
      if (drop[i]) begin
        req[i] = 1'b0; drop[i] = 1'b0;
      end else if (raise[i]) begin
        req[i] = 1'b1;
      end else if (!req[i] && p_new > 0 && int'($urandom_range(99)) < p_new) begin
        ra[i]  = DW'($urandom);
        rb[i]  = ($urandom_range(5) == 0) ? '0 : DW'($urandom);
        req[i] = 1'b1;
      end
      raise[i] = 1'b0;
      a_bus[i*DW +: DW] = ra[i];
      b_bus[i*DW +: DW] = rb[i];
    end
    fin = 1'b0;
    res = DW'($urandom);
    if (cyc == fin_cyc) begin
      fin = 1'b1; res = p_data;
    end else if (stray_en && !(cyc >= w_lo && cyc <= w_hi) && $urandom_range(3) == 0) begin
      fin = 1'b1;
    end
    if (cyc == rsp_cyc) begin
      e_id = p_id; e_data = p_data; e_err = p_err;
    end
    exp_busy = (cyc < next_grant);
    exp_gnt  = '0;
    granted  = 1'b0;
    gi       = 0;
    if (!exp_busy && req != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        k = (m_ptr + i) % NREQ;
        if (!granted && req[k]) begin granted = 1'b1; gi = k; end
      end
      exp_gnt[gi] = 1'b1;
    end
    @(negedge clk);
    check("gnt",      gnt, exp_gnt);
    check("busy",     busy, exp_busy);
    check("div_en",   div_en, (cyc == en_cyc));
    check("div_a",    div_a, m_a);
    check("div_b",    div_b, m_b);
    check("rsp_vld",  rsp_vld, (cyc == rsp_cyc));
    check("rsp_id",   rsp_id, e_id);
    check("rsp_data", rsp_data, e_data);
    check("rsp_err",  rsp_err, e_err);
    if (granted) begin
      m_ptr = (gi + 1) % NREQ;
      drop[gi] = 1'b1;
      gl.push_back(gi);
      gc.push_back(cyc);
      m_a = ra[gi];
      m_b = rb[gi];
      p_id = '0;
      p_id[gi] = 1'b1;
      lat = (fix_lat == LAT_RAND) ? int'($urandom_range(6, 1)) : fix_lat;
      if (m_b == '0) begin
        en_cyc = -1; fin_cyc = -1; w_lo = -1; w_hi = -1;
        rsp_cyc = cyc + 2; p_data = 16'h7FFF; p_err = 1'b1;
      end else begin
        en_cyc = cyc + 1;
        w_lo   = cyc + 2;
        if (lat == NOFIN) begin
          fin_cyc = -1;
`ifdef DIV_ARB_TIMEOUT_EN
          rsp_cyc = cyc + 2 + TMO; w_hi = rsp_cyc - 1; p_data = '0; p_err = 1'b1;
`else
          rsp_cyc = FOREVER; w_hi = FOREVER;
`endif
        end else begin
          fin_cyc = cyc + 1 + lat; rsp_cyc = fin_cyc + 1; w_hi = fin_cyc;
          p_data = model_div(m_a, m_b); p_err = 1'b0;
        end
      end
      next_grant = rsp_cyc + 1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((cyc < next_grant || req != '0) && n < 300) begin
      step();
      n++;
    end
    check("drain_bound", (n < 300), 1);
  endtask

  task automatic single(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input int lat);
    ra[k] = a; rb[k] = b; raise[k] = 1'b1; fix_lat = lat;
    step();
  endtask

  task automatic reset_mid();
    #2;
    rst_n = 1'b0;
    req   = '0;
    fin   = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_hold_vld", rsp_vld, 0);
    check("rst_hold_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; fin = 1'b0; res = '0; a_bus = '0; b_bus = '0;
    p_new = 0; stray_en = 1'b0; fix_lat = LAT_RAND;
    for (int i = 0; i < NREQ; i++) begin ra[i] = '0; rb[i] = '0; end
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Contention at minimum latency from ptr=0
    for (int i = 0; i < NREQ; i++) begin ra[i] = DW'(16'h0100 * (i + 1)); rb[i] = DW'(16'h0040 + i); end
    gl.delete(); gc.delete();
    raise = '1; fix_lat = 1;
    step();
    drain();
    check("cont_count", gl.size(), NREQ);
    for (int i = 0; i < NREQ && i < gl.size(); i++) begin
      check("cont_order", gl[i], i);
      if (i > 0) check("cont_gap", gc[i] - gc[i-1], 4);
    end

    stray_en = 1'b1;
    single(1, 16'h2000, 16'h4000, 5);
    drain();

    // Pointer fairness: after requester 2, a 0101 request goes to requester 0
    single(2, 16'h1111, 16'h0333, LAT_RAND);
    drain();
    gl.delete();
    ra[0] = 16'h0A00; rb[0] = 16'h0010; ra[2] = 16'h0B00; rb[2] = 16'h0020;
    raise = 4'b0101; fix_lat = 2;
    step();
    drain();
    check("fair_count", gl.size(), 2);
    if (gl.size() > 0) check("fair_first", gl[0], 0);

    single(3, 16'h4321, 16'h0000, LAT_RAND);
    drain();

`ifdef DIV_ARB_TIMEOUT_EN
    single(0, 16'h0777, 16'h0005, NOFIN);
    drain();
    single(0, 16'h0888, 16'h0006, TMO);
    drain();
    single(1, 16'h1234, 16'h0042, NOFIN);
    repeat (3) step();
`else
    single(1, 16'h1234, 16'h0042, NOFIN);
    repeat (100) step();
`endif
    reset_mid();

    gl.delete();
    raise = '1; fix_lat = LAT_RAND;
    step();
    drain();
    check("post_rst_count", gl.size(), NREQ);
    if (gl.size() > 0) check("post_rst_first", gl[0], 0);

    p_new = 30; fix_lat = LAT_RAND;
    repeat (800) step();
    p_new = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
